// File: rtl/qea_state_readout.sv
// Reads the QEA state RAM word by word after a run and serializes every
// PE_NUM-wide word into one complex amplitude per beat on a valid/ready stream.
module qea_state_readout #(
    parameter int PE_NUM           = 4,
    parameter int PE_NUM_WIDTH     = 2,
    parameter int DATA_WIDTH       = 32,
    parameter int STATE_DATA_WIDTH = 64,
    parameter int STATE_ADDR_WIDTH = 16,
    parameter int MAX_QBIT_WIDTH   = 6,
    parameter int RAM_RD_LATENCY   = 2
) (
    input  logic                                   clk,
    input  logic                                   rst,
    input  logic                                   i_start,
    input  logic [MAX_QBIT_WIDTH-1:0]              i_qbit_num,
    output logic                                   o_busy,
    output logic                                   o_done,
    output logic                                   o_err,
    output logic [PE_NUM-1:0]                      o_state_ena,
    output logic [PE_NUM-1:0]                      o_state_wea,
    output logic [STATE_ADDR_WIDTH-1:0]            o_state_addra,
    input  logic [PE_NUM*STATE_DATA_WIDTH-1:0]     i_state_dout,
    output logic                                   o_amp_valid,
    input  logic                                   i_amp_ready,
    output logic [STATE_DATA_WIDTH-1:0]            o_amp_data,
    output logic [STATE_ADDR_WIDTH+PE_NUM_WIDTH-1:0] o_amp_index,
    output logic                                   o_amp_last
);

    localparam int CNT_W = 3;
    localparam logic [PE_NUM_WIDTH-1:0] LAST_LANE = PE_NUM_WIDTH'(PE_NUM - 1);
    localparam logic [CNT_W-1:0]        WAIT_LOAD = CNT_W'(RAM_RD_LATENCY - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_RD,
        S_WAIT,
        S_STREAM,
        S_DONE
    } state_t;

    state_t                        state_q, state_d;
    logic [STATE_ADDR_WIDTH-1:0]   addr_q, addr_d;
    logic [STATE_ADDR_WIDTH-1:0]   last_addr_q, last_addr_d;
    logic [STATE_ADDR_WIDTH-1:0]   start_last_addr;
    logic [STATE_ADDR_WIDTH:0]     start_words;
    logic [MAX_QBIT_WIDTH-1:0]     start_shift;
    logic [PE_NUM_WIDTH-1:0]       lane_q, lane_d;
    logic [CNT_W-1:0]              cnt_q, cnt_d;
    logic                          err_q, err_d;
    logic                          err_done_q, err_done_d;
    logic                          start_ok;
    logic                          capture;
    logic [PE_NUM*STATE_DATA_WIDTH-1:0] word_q;
    logic [DATA_WIDTH-1:0]         amp_re, amp_im;

    assign start_ok = i_qbit_num >= MAX_QBIT_WIDTH'(PE_NUM_WIDTH);

    // Last word address W-1 = 2^(n-PE_NUM_WIDTH)-1, saturated to the full address space.
    always_comb begin
        start_shift     = i_qbit_num - MAX_QBIT_WIDTH'(PE_NUM_WIDTH);
        start_words     = '0;
        start_last_addr = '1;
        if (start_shift < MAX_QBIT_WIDTH'(STATE_ADDR_WIDTH)) begin
            start_words     = (STATE_ADDR_WIDTH+1)'(1) << start_shift;
            start_last_addr = STATE_ADDR_WIDTH'(start_words - (STATE_ADDR_WIDTH+1)'(1));
        end
    end

    // NOTE: every signal assigned here gets a default first, so no path can infer a latch.
    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        last_addr_d = last_addr_q;
        lane_d      = lane_q;
        cnt_d       = cnt_q;
        err_d       = err_q;
        err_done_d  = 1'b0;
        capture     = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                if (i_start) begin
                    if (start_ok) begin
                        last_addr_d = start_last_addr;
                        addr_d      = '0;
                        err_d       = 1'b0;
                        state_d     = S_RD;
                    end else begin
                        err_d      = 1'b1;
                        err_done_d = 1'b1;
                    end
                end
            end
            S_RD: begin
                cnt_d   = WAIT_LOAD;
                state_d = S_WAIT;
            end
            S_WAIT: begin
                if (cnt_q == '0) begin
                    capture = 1'b1;
                    lane_d  = '0;
                    state_d = S_STREAM;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            S_STREAM: begin
                if (i_amp_ready) begin
                    if (lane_q != LAST_LANE) begin
                        lane_d = lane_q + PE_NUM_WIDTH'(1);
                    end else if (addr_q != last_addr_q) begin
                        addr_d  = addr_q + STATE_ADDR_WIDTH'(1);
                        state_d = S_RD;
                    end else begin
                        state_d = S_DONE;
                    end
                end
            end
            S_DONE: state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            addr_q      <= '0;
            last_addr_q <= '0;
            lane_q      <= '0;
            cnt_q       <= '0;
            err_q       <= 1'b0;
            err_done_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            last_addr_q <= last_addr_d;
            lane_q      <= lane_d;
            cnt_q       <= cnt_d;
            err_q       <= err_d;
            err_done_q  <= err_done_d;
        end
    end

    // NOTE: the word register has no reset; it is only observed in STREAM, always after a capture.
    always_ff @(posedge clk) begin
        if (capture) begin
            word_q <= i_state_dout;
        end
    end

    // Lane 0 is the most significant slice of the word; each slice is {real, imag}.
    always_comb begin
        amp_re = '0;
        amp_im = '0;
        for (int k = 0; k < PE_NUM; k++) begin
            if (lane_q == PE_NUM_WIDTH'(k)) begin
                amp_re = word_q[(PE_NUM-k)*STATE_DATA_WIDTH-1 -: DATA_WIDTH];
                amp_im = word_q[(PE_NUM-k)*STATE_DATA_WIDTH-DATA_WIDTH-1 -: DATA_WIDTH];
            end
        end
    end

    assign o_busy        = (state_q != S_IDLE);
    assign o_done        = (state_q == S_DONE) || err_done_q;
    assign o_err         = err_q;
    assign o_state_ena   = {PE_NUM{state_q == S_RD}};
    assign o_state_wea   = '0;
    assign o_state_addra = addr_q;

    assign o_amp_valid = (state_q == S_STREAM);
    assign o_amp_data  = o_amp_valid ? {amp_re, amp_im} : '0;
    assign o_amp_index = o_amp_valid ? {addr_q, lane_q} : '0;
    assign o_amp_last  = o_amp_valid && (addr_q == last_addr_q) && (lane_q == LAST_LANE);

endmodule
